// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter and master-to-slave crossbar with a per-access watchdog.
// The owning master's access is routed to the slave decoded from its top address bits.
module bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int NUM_SLAVES  = 8,
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32,
    parameter int SIDX_W      = 3,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_req_n,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]        m_as_n,
    input  logic [NUM_MASTERS-1:0]        m_rw,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wr_data,
    output logic [NUM_MASTERS-1:0]        m_grnt_n,
    output logic [DATA_W-1:0]             m_rd_data,
    output logic                          m_rdy_n,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [NUM_SLAVES-1:0]         s_as_n,
    output logic                          s_rw,
    output logic [DATA_W-1:0]             s_wr_data,
    input  logic [NUM_SLAVES*DATA_W-1:0]  s_rd_data,
    input  logic [NUM_SLAVES-1:0]         s_rdy_n,
    output logic                          bus_err
);

    localparam int MW = $clog2(NUM_MASTERS);
    localparam int WW = $clog2(TIMEOUT);

    // state | meaning
    // IDLE  | no owner, all grants high
    // OWNED | owner holds the bus, its accesses are routed to the decoded slave
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OWNED = 1'b1;

    logic [0:0]             state;
    logic [MW-1:0]          owner;
    logic [MW-1:0]          last_owner;
    logic                   pending;
    logic [WW-1:0]          wdog;

    logic [MW-1:0]          winner;
    logic                   found;
    logic                   active;
    logic [ADDR_W-1:0]      own_addr;
    logic [SIDX_W-1:0]      sidx;
    logic                   as_fwd;
    logic                   slv_rdy;
    logic                   tmo;

    // Scan starts just past last_owner, so the previous owner always ranks last.
    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int'(last_owner) + k) % NUM_MASTERS;
            if (!found && !m_req_n[idx]) begin
                found  = 1'b1;
                winner = MW'(idx);
            end
        end
    end

    always_comb begin
        active   = (state == OWNED) && !rst;
        own_addr = m_addr[int'(owner)*ADDR_W +: ADDR_W];
        sidx     = own_addr[ADDR_W-1 -: SIDX_W];
        as_fwd   = active && !pending && !m_as_n[owner];
        slv_rdy  = active && pending && !s_rdy_n[sidx];
        tmo      = active && pending && (wdog == '0) && !slv_rdy;

        s_addr    = '0;
        s_rw      = 1'b0;
        s_wr_data = '0;
        s_as_n    = '1;
        if (active) begin
            s_addr    = own_addr;
            s_rw      = m_rw[owner];
            s_wr_data = m_wr_data[int'(owner)*DATA_W +: DATA_W];
        end
        if (as_fwd)
            s_as_n[sidx] = 1'b0;

        m_rdy_n   = !(slv_rdy || tmo);
        m_rd_data = slv_rdy ? s_rd_data[int'(sidx)*DATA_W +: DATA_W] : '0;
        bus_err   = tmo;
    end

    // The watchdog is a down-counter loaded when the strobe is forwarded; zero is terminal.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= MW'(NUM_MASTERS - 1);
            m_grnt_n   <= '1;
            pending    <= 1'b0;
            wdog       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        m_grnt_n   <= ~(NUM_MASTERS'(1) << winner);
                        owner      <= winner;
                        last_owner <= winner;
                        state      <= OWNED;
                    end
                end
                default: begin
                    if (m_req_n[owner]) begin
                        pending <= 1'b0;
                        wdog    <= '0;
                        if (found) begin
                            m_grnt_n   <= ~(NUM_MASTERS'(1) << winner);
                            owner      <= winner;
                            last_owner <= winner;
                        end else begin
                            m_grnt_n <= '1;
                            state    <= IDLE;
                        end
                    end else if (as_fwd) begin
                        pending <= 1'b1;
                        wdog    <= WW'(TIMEOUT - 1);
                    end else if (pending) begin
                        if (slv_rdy || tmo) begin
                            pending <= 1'b0;
                            wdog    <= '0;
                        end else begin
                            wdog <= wdog - 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a per-cycle vector table plus a hand-written watchdog sequence.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_bus_arbiter;

    localparam logic [31:0] W0 = 32'h1111_1111;
    localparam logic [31:0] W1 = 32'h2222_2222;
    localparam logic [31:0] W2 = 32'h3333_3333;
    localparam logic [31:0] W3 = 32'h1234_5678;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   m_req_n;
    logic [119:0] m_addr;
    logic [3:0]   m_as_n;
    logic [3:0]   m_rw;
    logic [127:0] m_wr_data;
    logic [3:0]   m_grnt_n;
    logic [31:0]  m_rd_data;
    logic         m_rdy_n;
    logic [29:0]  s_addr;
    logic [7:0]   s_as_n;
    logic         s_rw;
    logic [31:0]  s_wr_data;
    logic [255:0] s_rd_data;
    logic [7:0]   s_rdy_n;
    logic         bus_err;

    int n_vec  = 0;
    int n_miss = 0;

    bus_arbiter #(
        .NUM_MASTERS(4), .NUM_SLAVES(8), .ADDR_W(30), .DATA_W(32), .SIDX_W(3), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req_n(m_req_n), .m_addr(m_addr), .m_as_n(m_as_n), .m_rw(m_rw),
        .m_wr_data(m_wr_data), .m_grnt_n(m_grnt_n), .m_rd_data(m_rd_data), .m_rdy_n(m_rdy_n),
        .s_addr(s_addr), .s_as_n(s_as_n), .s_rw(s_rw), .s_wr_data(s_wr_data),
        .s_rd_data(s_rd_data), .s_rdy_n(s_rdy_n), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req_n;
        logic [3:0]  as_n;
        logic [7:0]  s_rdy_n;
        logic [3:0]  e_grnt;
        logic [7:0]  e_sas;
        logic        e_rdy;
        logic [31:0] e_rd;
        logic        e_err;
        logic        e_rw;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] as,
                       input logic [7:0] sr, input logic [3:0] g, input logic [7:0] sa,
                       input logic rdy, input logic [31:0] rd, input logic err,
                       input logic rw, input logic [31:0] wd);
        vec_t v;
        v.rst = r; v.req_n = rq; v.as_n = as; v.s_rdy_n = sr;
        v.e_grnt = g; v.e_sas = sa; v.e_rdy = rdy; v.e_rd = rd;
        v.e_err = err; v.e_rw = rw; v.e_wd = wd;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] as,
                         input logic [7:0] sr);
        @(posedge clk);
        #1;
        rst = r; m_req_n = rq; m_as_n = as; s_rdy_n = sr;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [83:0] act_v;
        logic [83:0] exp_v;
        int          cnt;

        rst       = 1'b1;
        m_req_n   = 4'hF;
        m_as_n    = 4'hF;
        s_rdy_n   = 8'hFF;
        // master 0 -> slave 2, master 1 -> slave 1, master 2 -> slave 4, master 3 -> slave 7
        m_addr    = {30'h3800_0000, 30'h2000_0000, 30'h0800_0000, 30'h1000_0010};
        m_rw      = 4'b0111;
        m_wr_data = {W3, W2, W1, W0};
        for (int s = 0; s < 8; s++)
            s_rd_data[s*32 +: 32] = 32'hD000_0000 | 32'(s);
        s_rd_data[2*32 +: 32] = 32'hCAFE_0001;

        //   rst req   as    s_rdy  grnt  s_as   rdy rd            err rw wd
        // reset, single request, slave answers two cycles after the strobe
        add(1, 4'hF, 4'hF, 8'hFF, 4'hF, 8'hFF, 1, 32'h0,         0, 0, 32'h0);
        add(0, 4'hE, 4'hF, 8'hFF, 4'hF, 8'hFF, 1, 32'h0,         0, 0, 32'h0);
        add(0, 4'hE, 4'hE, 8'hFF, 4'hE, 8'hFB, 1, 32'h0,         0, 1, W0);
        add(0, 4'hE, 4'hF, 8'hFF, 4'hE, 8'hFF, 1, 32'h0,         0, 1, W0);
        add(0, 4'hE, 4'hF, 8'hFB, 4'hE, 8'hFF, 0, 32'hCAFE_0001, 0, 1, W0);
        add(0, 4'hF, 4'hF, 8'hFF, 4'hE, 8'hFF, 1, 32'h0,         0, 1, W0);
        add(0, 4'hF, 4'hF, 8'hFF, 4'hF, 8'hFF, 1, 32'h0,         0, 0, 32'h0);
        // round robin with direct handover: 0,1,2,3,0
        add(1, 4'hF, 4'hF, 8'hFF, 4'hF, 8'hFF, 1, 32'h0,         0, 0, 32'h0);
        add(0, 4'h0, 4'hF, 8'hFF, 4'hF, 8'hFF, 1, 32'h0,         0, 0, 32'h0);
        add(0, 4'h0, 4'hE, 8'hFF, 4'hE, 8'hFB, 1, 32'h0,         0, 1, W0);
        add(0, 4'h0, 4'hF, 8'hFB, 4'hE, 8'hFF, 0, 32'hCAFE_0001, 0, 1, W0);
        add(0, 4'h1, 4'hF, 8'hFF, 4'hE, 8'hFF, 1, 32'h0,         0, 1, W0);
        add(0, 4'h1, 4'hD, 8'hFF, 4'hD, 8'hFD, 1, 32'h0,         0, 1, W1);
        add(0, 4'h1, 4'hF, 8'hFD, 4'hD, 8'hFF, 0, 32'hD000_0001, 0, 1, W1);
        add(0, 4'h3, 4'hF, 8'hFF, 4'hD, 8'hFF, 1, 32'h0,         0, 1, W1);
        add(0, 4'h3, 4'hB, 8'hFF, 4'hB, 8'hEF, 1, 32'h0,         0, 1, W2);
        add(0, 4'h3, 4'hF, 8'hEF, 4'hB, 8'hFF, 0, 32'hD000_0004, 0, 1, W2);
        add(0, 4'h7, 4'hF, 8'hFF, 4'hB, 8'hFF, 1, 32'h0,         0, 1, W2);
        add(0, 4'h7, 4'h7, 8'hFF, 4'h7, 8'h7F, 1, 32'h0,         0, 0, W3);
        add(0, 4'h7, 4'hF, 8'h7F, 4'h7, 8'hFF, 0, 32'hD000_0007, 0, 0, W3);
        add(0, 4'hE, 4'hF, 8'hFF, 4'h7, 8'hFF, 1, 32'h0,         0, 0, W3);
        add(0, 4'hE, 4'hF, 8'hFF, 4'hE, 8'hFF, 1, 32'h0,         0, 1, W0);
        add(0, 4'hF, 4'hF, 8'hFF, 4'hE, 8'hFF, 1, 32'h0,         0, 1, W0);
        add(0, 4'hF, 4'hF, 8'hFF, 4'hF, 8'hFF, 1, 32'h0,         0, 0, 32'h0);
        // reset mid-access, then master 0 beats master 2; unsolicited rdy_ ignored
        add(0, 4'hD, 4'hF, 8'hFF, 4'hF, 8'hFF, 1, 32'h0,         0, 0, 32'h0);
        add(0, 4'hD, 4'hD, 8'hFF, 4'hD, 8'hFD, 1, 32'h0,         0, 1, W1);
        add(1, 4'hD, 4'hF, 8'hFD, 4'hD, 8'hFF, 1, 32'h0,         0, 0, 32'h0);
        add(0, 4'hA, 4'hF, 8'hFF, 4'hF, 8'hFF, 1, 32'h0,         0, 0, 32'h0);
        add(0, 4'hA, 4'hF, 8'hFB, 4'hE, 8'hFF, 1, 32'h0,         0, 1, W0);
        add(0, 4'hF, 4'hF, 8'hFF, 4'hE, 8'hFF, 1, 32'h0,         0, 1, W0);
        add(0, 4'hF, 4'hF, 8'hFF, 4'hF, 8'hFF, 1, 32'h0,         0, 0, 32'h0);

        @(posedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req_n, vecs[i].as_n, vecs[i].s_rdy_n);
            act_v = {m_grnt_n, s_as_n, m_rdy_n, m_rd_data, bus_err, s_rw, s_wr_data};
            exp_v = {vecs[i].e_grnt, vecs[i].e_sas, vecs[i].e_rdy, vecs[i].e_rd,
                     vecs[i].e_err, vecs[i].e_rw, vecs[i].e_wd};
            n_vec++;
            if (act_v !== exp_v) begin
                n_miss++;
                $display("FAIL vec%0d {grnt,s_as,rdy,rd,err,rw,wd}: got %h, expected %h",
                         i, act_v, exp_v);
            end
        end

        // watchdog: master 1 strobes slave 1, which never answers
        drive(0, 4'hD, 4'hF, 8'hFF);
        chk("wd_idle_grnt", 32'(m_grnt_n), 32'hF);
        drive(0, 4'hD, 4'hD, 8'hFF);
        chk("wd_grnt", 32'(m_grnt_n), 32'hD);
        chk("wd_as_fwd", 32'(s_as_n), 32'hFD);
        drive(0, 4'hD, 4'hD, 8'hFF);
        chk("wd_second_as", 32'(s_as_n), 32'hFF);
        chk("wd_second_as_rdy", 32'(m_rdy_n), 32'h1);
        cnt = 0;
        for (int k = 2; k <= 20; k++) begin
            drive(0, 4'hD, 4'hF, 8'hFF);
            if (m_rdy_n === 1'b0) begin
                cnt = k;
                break;
            end
        end
        chk("wd_cycles_after_as", 32'(cnt), 32'd8);
        chk("wd_bus_err", 32'(bus_err), 32'h1);
        chk("wd_rd_data", m_rd_data, 32'h0);
        drive(0, 4'hD, 4'hF, 8'hFD);
        chk("wd_late_rdy", 32'(m_rdy_n), 32'h1);
        chk("wd_err_once", 32'(bus_err), 32'h0);
        chk("wd_still_owner", 32'(m_grnt_n), 32'hD);
        drive(0, 4'hF, 4'hF, 8'hFF);
        chk("wd_release", 32'(m_grnt_n), 32'hD);
        drive(0, 4'hF, 4'hF, 8'hFF);
        chk("wd_idle_after", 32'(m_grnt_n), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
